pc_unit: RTL and testbench

Parametrised program-counter unit that supersedes the plain PC register in the single-cycle datapath. Holds the fetch address and advances it by 4 when the fetch stage accepts an address. Applies trap, branch-redirect, call/return and jump updates under a fixed priority. Contains a small return-address stack (RAS) for call/return prediction; it feeds the instruction-memory address port and takes redirect information from the execute stage.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_unit.sv | 129 ++++++++++++
 tb/tb_pc_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared constants, next-PC source encoding and word alignment
//            helper for the program-counter unit.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int INSTR_BYTES = 4;
    // Widest address the alignment helper handles; callers zero-extend into it.
    localparam int MAX_XLEN    = 64;

    typedef enum logic [2:0] {
        SRC_HOLD  = 3'd0,
        SRC_SEQ   = 3'd1,
        SRC_JUMP  = 3'd2,
        SRC_RET   = 3'd3,
        SRC_REDIR = 3'd4,
        SRC_TRAP  = 3'd5
    } pc_src_e;

    function automatic logic [MAX_XLEN-1:0] align_word(input logic [MAX_XLEN-1:0] addr);
        return addr & ~MAX_XLEN'(3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module   : pc_ras
// Purpose  : Circular return-address stack; a push when full overwrites the
//            oldest entry. Pointer and count clear asynchronously on clr.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ras #(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              push_data,
    output logic [XLEN-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int c_ptr_w = $clog2(RAS_DEPTH);

    logic [XLEN-1:0]    r_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [c_ptr_w-1:0] w_top_idx;
    logic               w_pop;

    // r_ptr is the next free slot; the top of stack sits just below it.
    assign w_top_idx = r_ptr - c_ptr_w'(1);
    assign top       = r_mem[w_top_idx];
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_ptr_w+1)'(RAS_DEPTH));
    assign w_pop     = pop & ~empty;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            unique case ({push, w_pop})
                2'b10: begin
                    r_ptr <= r_ptr + c_ptr_w'(1);
                    if (!full) begin
                        r_count <= r_count + (c_ptr_w+1)'(1);
                    end
                end
                2'b01: begin
                    r_ptr   <= w_top_idx;
                    r_count <= r_count - (c_ptr_w+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Simultaneous push and pop replaces the top entry in place.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_pop ? w_top_idx : r_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Fetch program counter with trap/redirect/return/jump priority
//            flushes, sequential advance and a return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    output logic                       fetch_valid,
    input  logic                       fetch_ready,
    input  logic                       stall,
    input  logic                       trap,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_target,
    input  logic                       jump_valid,
    input  logic [XLEN-1:0]            jump_target,
    input  logic                       jump_link,
    input  logic                       ret_valid,
    output logic [XLEN-1:0]            pc,
    output logic                       misalign,
    output logic                       ras_underflow,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);

    logic [XLEN-1:0]     r_pc;
    logic                r_fetch_valid;
    logic                r_misalign;
    logic                r_underflow;

    pc_src_e             w_src;
    logic [XLEN-1:0]     w_raw;
    logic [XLEN-1:0]     w_pc_inc;
    logic [XLEN-1:0]     w_aligned;
    logic [MAX_XLEN-1:0] w_al_ext;
    logic                w_accept;
    logic                w_flush;
    logic                w_misalign;
    logic                w_underflow;
    logic                w_push;
    logic                w_pop;
    logic [XLEN-1:0]     w_ras_top;
    logic                w_ras_empty;
    logic                w_ras_full_unused;

    assign w_accept = r_fetch_valid & fetch_ready & ~stall;
    assign w_pc_inc = r_pc + XLEN'(INSTR_BYTES);

    always_comb begin
        w_src = SRC_HOLD;
        w_raw = r_pc;
        if (trap) begin
            w_src = SRC_TRAP;
            w_raw = TRAP_VECTOR;
        end else if (redirect_valid) begin
            w_src = SRC_REDIR;
            w_raw = redirect_target;
        end else if (ret_valid) begin
            w_src = SRC_RET;
            w_raw = w_ras_empty ? TRAP_VECTOR : w_ras_top;
        end else if (jump_valid) begin
            w_src = SRC_JUMP;
            w_raw = jump_target;
        end else if (w_accept) begin
            w_src = SRC_SEQ;
            w_raw = w_pc_inc;
        end
    end

    assign w_flush     = (w_src != SRC_HOLD) && (w_src != SRC_SEQ);
    assign w_misalign  = w_flush & (|w_raw[1:0]);
    assign w_underflow = (w_src == SRC_RET) & w_ras_empty;
    assign w_push      = (w_src == SRC_JUMP) & jump_link;
    assign w_pop       = (w_src == SRC_RET) & ~w_ras_empty;
    assign w_al_ext    = align_word(MAX_XLEN'(w_raw));

    if (XLEN < MAX_XLEN) begin : g_trunc
        logic [MAX_XLEN-XLEN-1:0] w_unused_hi;
        assign {w_unused_hi, w_aligned} = w_al_ext;
    end else begin : g_full
        assign w_aligned = w_al_ext;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_fetch_valid <= 1'b1;
            r_misalign    <= w_misalign;
            r_underflow   <= w_underflow;
            if (w_src != SRC_HOLD) begin
                r_pc <= w_aligned;
            end
        end
    end

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk       (clk),
        .clr       (clr),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_ras_top),
        .count     (ras_count),
        .empty     (w_ras_empty),
        .full      (w_ras_full_unused)
    );

    assign pc            = r_pc;
    assign fetch_valid   = r_fetch_valid;
    assign misalign      = r_misalign;
    assign ras_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Scoreboard bench for pc_unit (RESET_VECTOR 0x1000, TRAP 0x100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk, clr;
    logic        fetch_valid, fetch_ready, stall, trap;
    logic        redirect_valid, jump_valid, jump_link, ret_valid;
    logic [31:0] redirect_target, jump_target, pc;
    logic        misalign, ras_underflow;
    logic [2:0]  ras_count;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        mis;
        logic        unf;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_1000),
        .TRAP_VECTOR  (32'h0000_0100),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .clr             (clr),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .stall           (stall),
        .trap            (trap),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .jump_valid      (jump_valid),
        .jump_target     (jump_target),
        .jump_link       (jump_link),
        .ret_valid       (ret_valid),
        .pc              (pc),
        .misalign        (misalign),
        .ras_underflow   (ras_underflow),
        .ras_count       (ras_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic t, input logic rv, input logic [31:0] rt,
                         input logic jv, input logic [31:0] jt, input logic jl,
                         input logic rtn, input logic fr, input logic st);
        trap = t; redirect_valid = rv; redirect_target = rt;
        jump_valid = jv; jump_target = jt; jump_link = jl;
        ret_valid = rtn; fetch_ready = fr; stall = st;
    endtask

    task automatic sb_push(input logic [31:0] p, input logic fv, input logic mis,
                           input logic unf, input logic [2:0] cnt);
        exp_t x;
        x.pc = p; x.fv = fv; x.mis = mis; x.unf = unf; x.cnt = cnt;
        sb.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_seq;
        logic [31:0] exp_pc [8];
        logic        st_v   [8];
        exp_pc = '{32'h1000, 32'h1004, 32'h1008, 32'h1008, 32'h1008, 32'h1008, 32'h100C, 32'h1010};
        st_v   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        #2;
        sb_push(32'h1000, 1'b0, 1'b0, 1'b0, 3'd0);
        e = sb.pop_front();
        n_tests++;
        if ({pc, fetch_valid, misalign, ras_underflow, ras_count} !== e) begin
            n_fail++;
            $display("FAIL reset: got pc=%h fv=%b mis=%b unf=%b cnt=%0d, expected pc=%h fv=%b mis=%b unf=%b cnt=%0d",
                     pc, fetch_valid, misalign, ras_underflow, ras_count, e.pc, e.fv, e.mis, e.unf, e.cnt);
        end
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, st_v[i]);
            sb_push(exp_pc[i], 1'b1, 1'b0, 1'b0, 3'd0);
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({pc, fetch_valid, misalign, ras_underflow, ras_count} !== e) begin
                n_fail++;
                $display("FAIL seq_stall step %0d: got pc=%h fv=%b mis=%b unf=%b cnt=%0d, expected pc=%h fv=%b mis=%b unf=%b cnt=%0d",
                         i, pc, fetch_valid, misalign, ras_underflow, ras_count, e.pc, e.fv, e.mis, e.unf, e.cnt);
            end
        end
    endtask

    task automatic test_call_return;
        for (int i = 0; i < 2; i++) begin
            case (i)
                0: begin drive(0, 0, 0, 1, 32'h4000, 1, 0, 1, 0); sb_push(32'h4000, 1, 0, 0, 3'd1); end
                default: begin drive(0, 0, 0, 0, 0, 0, 1, 1, 0); sb_push(32'h1014, 1, 0, 0, 3'd0); end
            endcase
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({pc, fetch_valid, misalign, ras_underflow, ras_count} !== e) begin
                n_fail++;
                $display("FAIL call_return step %0d: got pc=%h fv=%b mis=%b unf=%b cnt=%0d, expected pc=%h fv=%b mis=%b unf=%b cnt=%0d",
                         i, pc, fetch_valid, misalign, ras_underflow, ras_count, e.pc, e.fv, e.mis, e.unf, e.cnt);
            end
        end
    endtask

    task automatic test_priority;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin drive(0, 0, 0, 1, 32'h5000, 1, 0, 1, 0); sb_push(32'h5000, 1, 0, 0, 3'd1); end
                1: begin drive(1, 1, 32'h2000, 1, 32'h3000, 1, 0, 1, 0); sb_push(32'h0100, 1, 0, 0, 3'd1); end
                2: begin drive(0, 1, 32'h2000, 0, 0, 0, 1, 1, 0); sb_push(32'h2000, 1, 0, 0, 3'd1); end
                3: begin drive(0, 0, 0, 1, 32'h3000, 1, 1, 1, 0); sb_push(32'h1018, 1, 0, 0, 3'd0); end
                default: begin drive(0, 1, 32'h2400, 0, 0, 0, 0, 1, 1); sb_push(32'h2400, 1, 0, 0, 3'd0); end
            endcase
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({pc, fetch_valid, misalign, ras_underflow, ras_count} !== e) begin
                n_fail++;
                $display("FAIL priority step %0d: got pc=%h fv=%b mis=%b unf=%b cnt=%0d, expected pc=%h fv=%b mis=%b unf=%b cnt=%0d",
                         i, pc, fetch_valid, misalign, ras_underflow, ras_count, e.pc, e.fv, e.mis, e.unf, e.cnt);
            end
        end
    endtask

    task automatic test_ras_overflow;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                drive(0, 1, 32'h1000, 0, 0, 0, 0, 1, 0);
                sb_push(32'h1000, 1, 0, 0, 3'd0);
            end else if (i <= 5) begin
                drive(0, 0, 0, 1, 32'h1000 + 32'h100 * i, 1, 0, 1, 0);
                sb_push(32'h1000 + 32'h100 * i, 1, 0, 0, (i > 4) ? 3'd4 : 3'(i));
            end else if (i <= 9) begin
                drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
                sb_push(32'h1404 - 32'h100 * (i - 6), 1, 0, 0, 3'(9 - i));
            end else if (i == 10) begin
                drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
                sb_push(32'h0100, 1, 0, 1, 3'd0);
            end else begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                sb_push(32'h0100, 1, 0, 0, 3'd0);
            end
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({pc, fetch_valid, misalign, ras_underflow, ras_count} !== e) begin
                n_fail++;
                $display("FAIL ras_overflow step %0d: got pc=%h fv=%b mis=%b unf=%b cnt=%0d, expected pc=%h fv=%b mis=%b unf=%b cnt=%0d",
                         i, pc, fetch_valid, misalign, ras_underflow, ras_count, e.pc, e.fv, e.mis, e.unf, e.cnt);
            end
        end
    endtask

    task automatic test_misalign_wrap;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(0, 1, 32'h2003, 0, 0, 0, 0, 1, 0); sb_push(32'h2000, 1, 1, 0, 3'd0); end
                1: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); sb_push(32'h2000, 1, 0, 0, 3'd0); end
                2: begin drive(0, 0, 0, 1, 32'h3002, 0, 0, 0, 0); sb_push(32'h3000, 1, 1, 0, 3'd0); end
                3: begin drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 0); sb_push(32'hFFFF_FFFC, 1, 0, 0, 3'd0); end
                4: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); sb_push(32'h0000_0000, 1, 0, 0, 3'd0); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); sb_push(32'h0000_0004, 1, 0, 0, 3'd0); end
            endcase
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({pc, fetch_valid, misalign, ras_underflow, ras_count} !== e) begin
                n_fail++;
                $display("FAIL misalign_wrap step %0d: got pc=%h fv=%b mis=%b unf=%b cnt=%0d, expected pc=%h fv=%b mis=%b unf=%b cnt=%0d",
                         i, pc, fetch_valid, misalign, ras_underflow, ras_count, e.pc, e.fv, e.mis, e.unf, e.cnt);
            end
        end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(0, 0, 0, 1, 32'h6000, 1, 0, 1, 0); sb_push(32'h6000, 1, 0, 0, 3'd1); end
                1: begin drive(0, 0, 0, 1, 32'h7000, 1, 0, 1, 0); sb_push(32'h7000, 1, 0, 0, 3'd2); end
                2: begin
                    // Assert clr between edges; state must clear before the next edge.
                    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
                    #2 clr = 1'b1;
                    sb_push(32'h1000, 0, 0, 0, 3'd0);
                    #1;
                end
                3: begin #2 clr = 1'b0; sb_push(32'h1000, 1, 0, 0, 3'd0); end
                4: begin sb_push(32'h1004, 1, 0, 0, 3'd0); end
                default: begin drive(0, 0, 0, 0, 0, 0, 1, 1, 0); sb_push(32'h0100, 1, 0, 1, 3'd0); end
            endcase
            if (i != 2) tick();
            e = sb.pop_front();
            n_tests++;
            if ({pc, fetch_valid, misalign, ras_underflow, ras_count} !== e) begin
                n_fail++;
                $display("FAIL mid_reset step %0d: got pc=%h fv=%b mis=%b unf=%b cnt=%0d, expected pc=%h fv=%b mis=%b unf=%b cnt=%0d",
                         i, pc, fetch_valid, misalign, ras_underflow, ras_count, e.pc, e.fv, e.mis, e.unf, e.cnt);
            end
        end
    endtask

    initial begin
        clr = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset_seq();
        test_call_return();
        test_priority();
        test_ras_overflow();
        test_misalign_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
